// File: rtl/dut_host_seq.sv
// Host-side sequencer: resets the core, preloads data memory, times the run until ack,
// then streams a result window out of data memory.
module dut_host_seq #(
  parameter logic [7:0]  LOAD_BASE   = 8'd0,
  parameter int unsigned LOAD_LEN    = 8,
  parameter logic [7:0]  RESULT_BASE = 8'd64,
  parameter int unsigned RESULT_LEN  = 4,
  parameter logic [15:0] TIMEOUT     = 16'd4000
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic        dut_init,
  output logic        dut_req,
  input  logic        dut_ack,
  output logic        host_own,
  output logic        mem_wen,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        res_valid,
  output logic [7:0]  res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] run_cycles
);

  localparam logic [7:0] LoadLast = 8'(LOAD_LEN - 1);
  localparam logic [7:0] ResLen   = 8'(RESULT_LEN);

  typedef enum logic [2:0] {StIdle, StRst, StLoad, StRun, StRead, StFin} state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        rst_cnt_q, rst_cnt_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic        timeout_q, timeout_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  logic        dut_init_q, dut_req_q, host_own_q, busy_q, done_q;
  logic        abort;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rst_cnt_d    = rst_cnt_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    abort        = 1'b0;
    load_ready   = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = 8'd0;
    mem_wdata    = 8'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRst;
          timeout_d    = 1'b0;
          run_cycles_d = 16'd0;
          idx_d        = 8'd0;
          rst_cnt_d    = 1'b0;
        end
      end
      StRst: begin
        rst_cnt_d = 1'b1;
        if (rst_cnt_q) state_d = StLoad;
      end
      StLoad: begin
        load_ready = 1'b1;
        mem_addr   = LOAD_BASE + idx_q;
        if (load_valid) begin
          mem_wen   = 1'b1;
          mem_wdata = load_data;
          if (idx_q == LoadLast) begin
            state_d = StRun;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StRun: begin
        if (run_cycles_q != 16'hFFFF) run_cycles_d = run_cycles_q + 16'd1;
        // run_cycles_q is zero only in the first RUN cycle, where the core still sees PC=0
        if (dut_ack && (run_cycles_q != 16'd0)) begin
          state_d = StRead;
        end else if (run_cycles_d == TIMEOUT) begin
          timeout_d = 1'b1;
          abort     = 1'b1;
          state_d   = StIdle;
        end
      end
      StRead: begin
        mem_addr = RESULT_BASE + idx_q;
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        if ((!res_valid_q || res_ready) && (idx_q != ResLen)) begin
          res_data_d  = mem_rdata;
          res_valid_d = 1'b1;
          idx_d       = idx_q + 8'd1;
        end else if (res_valid_q && res_ready && (idx_q == ResLen)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q      <= StIdle;
      idx_q        <= 8'd0;
      rst_cnt_q    <= 1'b0;
      run_cycles_q <= 16'd0;
      timeout_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 8'd0;
      dut_init_q   <= 1'b0;
      dut_req_q    <= 1'b0;
      host_own_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      dut_init_q   <= (state_d == StRst) || abort;
      dut_req_q    <= (state_d == StRst) || (state_d == StLoad);
      host_own_q   <= (state_d != StRun);
      busy_q       <= (state_d != StIdle);
      done_q       <= (state_d == StFin);
    end
  end

  assign dut_init   = dut_init_q;
  assign dut_req    = dut_req_q;
  assign host_own   = host_own_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_dut_host_seq.sv
// Scoreboard bench for dut_host_seq: a small core/memory fixture, queued expectations for
// memory writes and result bytes, and a negedge monitor that pops and compares.
module tb_dut_host_seq;
  localparam logic [7:0]  LB = 8'hFE;
  localparam int          LL = 8;
  localparam logic [7:0]  RB = 8'h40;
  localparam int          RL = 4;
  localparam logic [15:0] TO = 16'd100;

  logic        clk, init_n, start, load_valid, load_ready, dut_init, dut_req, dut_ack;
  logic        host_own, mem_wen, res_valid, res_ready, busy, done, timeout;
  logic [7:0]  load_data, mem_addr, mem_wdata, mem_rdata, res_data;
  logic [15:0] run_cycles;

  dut_host_seq #(
    .LOAD_BASE(LB), .LOAD_LEN(LL), .RESULT_BASE(RB), .RESULT_LEN(RL), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .init_n(init_n), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .dut_init(dut_init), .dut_req(dut_req),
    .dut_ack(dut_ack), .host_own(host_own), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy), .done(done),
    .timeout(timeout), .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int cyc;
  int stall_from = -100;
  bit rr_rand = 1'b0;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] ld [LL];

  // Data memory plus a stand-in core: its reset clears memory, and while it owns the port
  // it writes result[i] = loaded[i] ^ (0x5A + i).
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (dut_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (mem_wen) mem[mem_addr] <= mem_wdata;
      if (!host_own)
        for (int i = 0; i < RL; i++) mem[RB + 8'(i)] <= mem[LB + 8'(i)] ^ (8'h5A + 8'(i));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a result byte.
  always @(negedge clk) begin
    wr_t w;
    if (init_n) begin
      if (mem_wen) begin
        if (wq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected none", mem_addr, mem_wdata);
        end else begin
          w = wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w.a));
          chk("write_data", 32'(mem_wdata), 32'(w.d));
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: data %0h, expected none", res_data);
        end else if (res_ready) begin
          chk("result_byte", 32'(res_data), 32'(rq.pop_front()));
        end else begin
          chk("result_hold", 32'(res_data), 32'(rq[0]));
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (cyc >= stall_from && cyc < stall_from + 5) res_ready = 1'b0;
      else res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_strobes"}, 32'({dut_init, dut_req, load_ready, mem_wen, res_valid, busy, done,
                                timeout, host_own}), 32'h1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_res_data"}, 32'(res_data), 32'h0);
    chk({tag, "_run_cycles"}, 32'(run_cycles), 32'h0);
  endtask

  // Ends at the negedge of the first LOAD cycle.
  task automatic do_start();
    for (int i = 0; i < 50 && busy; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("rst_init", 32'(dut_init), 32'h1);
    chk("rst_req", 32'(dut_req), 32'h1);
    chk("start_clears_timeout", 32'(timeout), 32'h0);
    chk("start_clears_run_cycles", 32'(run_cycles), 32'h0);
    chk("rst_no_ready_c1", 32'(load_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("rst_no_ready_c2", 32'(load_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("first_load_ready", 32'(load_ready), 32'h1);
    chk("init_released", 32'(dut_init), 32'h0);
  endtask

  // Ends at posedge+1 of the cycle after the n-th handshake.
  task automatic load_bytes(input int n, input bit toggle);
    int k = 0;
    int guard = 0;
    wr_t w;
    tick();
    while (k < n && guard < 200) begin
      guard++;
      load_valid = toggle ? (guard % 2 == 1) : 1'b1;
      load_data  = ld[k];
      if (load_valid) begin
        w.a = LB + 8'(k);
        w.d = ld[k];
        wq.push_back(w);
      end
      @(posedge clk);
      if (load_valid) k++;
      #1;
    end
    load_valid = 1'b0;
    load_data  = 8'h00;
  endtask

  // Starts at posedge+1 of RUN cycle 1; ack_at >= 2. Ends at negedge of READ cycle 2.
  task automatic run_phase(input int ack_at, input bit early);
    for (int r = 1; r <= ack_at; r++) begin
      dut_ack = (r == ack_at) || (early && r == 1);
      @(negedge clk);
      if (r == 1) begin
        chk("run_req_low", 32'(dut_req), 32'h0);
        chk("run_host_release", 32'(host_own), 32'h0);
      end
      if (early && r == 2) chk("early_ack_ignored", 32'(host_own), 32'h0);
      @(posedge clk); #1;
    end
    dut_ack = 1'b0;
    for (int i = 0; i < RL; i++) rq.push_back(ld[i] ^ (8'h5A + 8'(i)));
    @(negedge clk);
    chk("run_cycles", 32'(run_cycles), 32'(ack_at));
    chk("ack_res_valid_c1", 32'(res_valid), 32'h0);
    chk("read_host_own", 32'(host_own), 32'h1);
    tick();
    @(negedge clk);
    chk("ack_res_valid_c2", 32'(res_valid), 32'h1);
  endtask

  task automatic finish_seq();
    int d0 = done_cnt;
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("seq_completes", 32'(busy), 32'h0);
    chk("done_pulses", 32'(done_cnt - d0), 32'h1);
    chk("results_drained", 32'(rq.size()), 32'h0);
    chk("writes_drained", 32'(wq.size()), 32'h0);
  endtask

  initial begin
    int d0;
    init_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = 8'h00; dut_ack = 1'b0;
    repeat (3) tick();
    check_reset("por");
    init_n = 1'b1;
    tick();

    // Nominal: bytes 1..8, ack on RUN cycle 20
    for (int i = 0; i < LL; i++) ld[i] = 8'(i + 1);
    do_start();
    load_bytes(LL, 1'b0);
    run_phase(20, 1'b0);
    finish_seq();

    // Backpressure on both sides
    for (int i = 0; i < LL; i++) ld[i] = 8'($urandom);
    do_start();
    load_bytes(LL, 1'b1);
    stall_from = cyc + 7 + 2;
    run_phase(7, 1'b0);
    finish_seq();

    // Early ack in the first RUN cycle
    for (int i = 0; i < LL; i++) ld[i] = 8'($urandom);
    do_start();
    load_bytes(LL, 1'b0);
    run_phase(9, 1'b1);
    finish_seq();

    // Reset in the middle of LOAD
    for (int i = 0; i < LL; i++) ld[i] = 8'($urandom);
    do_start();
    load_bytes(3, 1'b0);
    init_n = 1'b0;
    #1;
    check_reset("mid_load");
    load_valid = 1'b1;
    load_data  = 8'h77;
    #1;
    chk("mid_load_no_wen", 32'(mem_wen), 32'h0);
    repeat (2) tick();
    init_n = 1'b1;
    repeat (3) tick();
    chk("mid_load_idle", 32'(busy), 32'h0);
    load_valid = 1'b0;

    // Timeout with no ack
    for (int i = 0; i < LL; i++) ld[i] = 8'($urandom);
    d0 = done_cnt;
    do_start();
    load_bytes(LL, 1'b0);
    for (int r = 1; r < int'(TO); r++) @(posedge clk);
    @(negedge clk);
    chk("to_not_yet", 32'(timeout), 32'h0);
    chk("to_still_busy", 32'(busy), 32'h1);
    tick();
    @(negedge clk);
    chk("to_flag", 32'(timeout), 32'h1);
    chk("to_init_pulse", 32'(dut_init), 32'h1);
    chk("to_idle", 32'(busy), 32'h0);
    chk("to_run_cycles", 32'(run_cycles), 32'(TO));
    tick();
    @(negedge clk);
    chk("to_init_single", 32'(dut_init), 32'h0);
    chk("to_sticky", 32'(timeout), 32'h1);
    chk("to_no_done", 32'(done_cnt - d0), 32'h0);
    chk("to_writes_drained", 32'(wq.size()), 32'h0);

    // Randomized sequences; the first start also clears the sticky timeout
    rr_rand = 1'b1;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < LL; i++) ld[i] = 8'($urandom);
      do_start();
      load_bytes(LL, 1'($urandom_range(0, 1)));
      run_phase(int'($urandom_range(3, 40)), 1'($urandom_range(0, 1)));
      finish_seq();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dut_host_seq.md
# dut_host_seq

Host-side sequencer that drives the processor core's start/done handshake from the initiator end. It resets the core, preloads a block of data memory from a byte stream while holding the core parked, and releases `req`. It then times the run until `ack`, reads a result window back out of data memory, and streams it to the bench or host logic. It owns the data-memory port whenever the core is not running.

## Interface
Parameters:
- `LOAD_BASE`, 8'd0, first data-memory address written during preload
- `LOAD_LEN`, 8, preload byte count (1..255)
- `RESULT_BASE`, 8'd64, first data-memory address read back
- `RESULT_LEN`, 4, result byte count (1..255)
- `TIMEOUT`, 16'd4000, maximum RUN cycles before abort

Ports:
- `clk`  in  1  clock, all state on rising edge
- `init_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a sequence; sampled only in IDLE
- `load_valid`  in  1  preload byte available
- `load_data`  in  8  preload byte
- `load_ready`  out  1  preload byte accepted when `load_valid && load_ready`
- `dut_init`  out  1  core reset (active-high)
- `dut_req`  out  1  core start; the core's PC is held at 0 while high
- `dut_ack`  in  1  core done
- `host_own`  out  1  host drives the data-memory port (selects the external mux)
- `mem_wen`  out  1  data-memory write enable
- `mem_addr`  out  8  data-memory address
- `mem_wdata`  out  8  data-memory write data
- `mem_rdata`  in  8  data-memory read data, combinational on `mem_addr`
- `res_valid`  out  1  result byte valid
- `res_data`  out  8  result byte
- `res_ready`  in  1  result byte consumed when `res_valid && res_ready`
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse on successful completion
- `timeout`  out  1  sticky abort flag; cleared on the next accepted `start`
- `run_cycles`  out  16  RUN cycle count of the last sequence; saturates at 16'hFFFF

## Operation
- States: IDLE, RST, LOAD, RUN, READ, FIN.
- IDLE:
  - All strobes are low and `host_own`=1.
  - `start`=1 moves to RST, clears `timeout` and `run_cycles`, and zeroes the byte index `idx`.
- RST:
  - `dut_init`=1 and `dut_req`=1 for exactly 2 cycles, then LOAD.
  - The core's own reset clears data memory, so preload must follow RST.
- LOAD:
  - `dut_req`=1 and `load_ready`=1.
  - Each handshake asserts `mem_wen` in the same cycle, with `mem_addr`=LOAD_BASE+idx (8-bit wrap) and `mem_wdata`=`load_data`, then increments `idx`.
  - After handshake LOAD_LEN-1, move to RUN and reset `idx`.
  - Without `load_valid` the state stalls indefinitely.
- RUN:
  - `dut_req`=0, `host_own`=0, `mem_wen`=0.
  - `run_cycles` increments each cycle.
  - `dut_ack` is ignored in the first RUN cycle, because the core sees PC=0 there. From the second RUN cycle, `dut_ack`=1 moves to READ.
  - If `run_cycles` reaches TIMEOUT with no ack: set `timeout`, pulse `dut_init` for 1 cycle, and go to IDLE without pulsing `done`.
- READ:
  - `host_own`=1 and `mem_addr`=RESULT_BASE+idx.
  - When the output register is empty, or is being consumed this cycle, capture `mem_rdata` into `res_data`, set `res_valid`, and increment `idx`.
  - `res_data` is stable while `res_valid && !res_ready`.
  - After the last byte is consumed, go to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `init_n` low in any state returns to IDLE immediately and clears all outputs to their reset values.

## Timing
- Reset values:
  - `host_own`=1.
  - `dut_init`, `dut_req`, `load_ready`, `mem_wen`, `res_valid`, `busy`, `done`, `timeout` = 0.
  - `mem_addr`, `mem_wdata`, `res_data` = 0.
  - `run_cycles`=0.
- Registered (from state): `dut_init`, `dut_req`, `host_own`, `busy`, `done`, `timeout`, `run_cycles`, `res_*`.
- Combinational with `load_valid`: `mem_wen` and `mem_wdata`.
- Latency:
  - `start` to first `load_ready`: 3 cycles.
  - Last load handshake to `dut_req` low: 1 cycle.
  - `dut_ack` to first `res_valid`: 2 cycles.
- With `load_valid` and `res_ready` held high, total sequence = 3 + LOAD_LEN + run + 1 + RESULT_LEN + 1 cycles.
- `run_cycles` equals the number of cycles `dut_req` was low before ack was accepted.

## Test plan
- Reset mid-LOAD: pull `init_n` low after 3 bytes -> all outputs return to reset values the same cycle; IDLE; no further `mem_wen`.
- Nominal: LOAD_LEN=8 bytes 0x01..0x08, core acks on RUN cycle 20 -> writes to addresses 0..7 in order; `run_cycles`=20; result bytes read from 64..67 in order; one `done` pulse.
- Backpressure: `load_valid` toggles 1/0 and `res_ready` is low for 5 cycles mid-stream -> no dropped or duplicated bytes; `res_data` holds while stalled.
- Early ack: `dut_ack`=1 already in the first RUN cycle -> ignored; READ entered only on a later ack.
- Timeout: TIMEOUT=100, ack never asserted -> `timeout`=1 at cycle 100; one `dut_init` pulse; IDLE; no `done`. A following `start` clears `timeout`.
- Address wrap: LOAD_BASE=8'hFE, LOAD_LEN=4 -> writes to FE, FF, 00, 01.
